// File: rtl/basic_gates.sv
// basic_gates: bitwise AND / OR / NOT of two WIDTH-bit operands.
// Each result is available combinationally and as a registered copy.
// The registers have a synchronous active-high reset and a load enable.
// valid_q marks that the registers hold a sample taken since the last reset.
// Optional feature: define BASIC_GATES_XOR_EN to add an XOR path
// (xor_out combinational, xor_q registered).
module basic_gates #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] not_out,
    output logic [WIDTH-1:0] and_q,
    output logic [WIDTH-1:0] or_q,
    output logic [WIDTH-1:0] not_q,
    output logic             valid_q
`ifdef BASIC_GATES_XOR_EN
    ,
    output logic [WIDTH-1:0] xor_out,
    output logic [WIDTH-1:0] xor_q
`endif
);

    // Gate results are purely combinational and bitwise, so every bit
    // position is independent of its neighbours at any WIDTH.
    always_comb begin
        and_out = input1 & input2;
        or_out  = input1 | input2;
        not_out = ~input1;
    end

    // Result registers: reset clears everything and wins over en; with
    // en low the registers, including valid_q, simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            and_q   <= '0;
            or_q    <= '0;
            not_q   <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            and_q   <= and_out;
            or_q    <= or_out;
            not_q   <= not_out;
            valid_q <= 1'b1;
        end
    end

`ifdef BASIC_GATES_XOR_EN
    // XOR result, computed like the other gates.
    always_comb begin
        xor_out = input1 ^ input2;
    end

    // XOR result register, sharing the reset and enable rules above.
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_q <= '0;
        end else if (en) begin
            xor_q <= xor_out;
        end
    end
`endif

endmodule

// File: tb/tb_basic_gates.sv
// Testbench for basic_gates: one WIDTH=4 and one WIDTH=1 instance, checked
// against a per-bit truth-table model with directed and random stimulus.
// Define BASIC_GATES_XOR_EN to include the XOR path checks.
module tb_basic_gates;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] a4  = '0;
    logic [3:0] b4  = '0;
    logic [0:0] a1  = '0;
    logic [0:0] b1  = '0;

    logic [3:0] and_out4, or_out4, not_out4, and_q4, or_q4, not_q4;
    logic       valid_q4;
    logic [0:0] and_out1, or_out1, not_out1, and_q1, or_q1, not_q1;
    logic       valid_q1;
`ifdef BASIC_GATES_XOR_EN
    logic [3:0] xor_out4, xor_q4;
    logic [0:0] xor_out1, xor_q1;
`endif

    int checks   = 0;
    int failures = 0;

    // Expected register contents (4-bit view; the 1-bit instance sees bit 0).
    logic [3:0] exp_and_q, exp_or_q, exp_not_q, exp_xor_q;
    logic       exp_valid;

    basic_gates #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .input1(a4), .input2(b4),
        .and_out(and_out4), .or_out(or_out4), .not_out(not_out4),
        .and_q(and_q4), .or_q(or_q4), .not_q(not_q4), .valid_q(valid_q4)
`ifdef BASIC_GATES_XOR_EN
        , .xor_out(xor_out4), .xor_q(xor_q4)
`endif
    );

    basic_gates #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .input1(a1), .input2(b1),
        .and_out(and_out1), .or_out(or_out1), .not_out(not_out1),
        .and_q(and_q1), .or_q(or_q1), .not_q(not_q1), .valid_q(valid_q1)
`ifdef BASIC_GATES_XOR_EN
        , .xor_out(xor_out1), .xor_q(xor_q1)
`endif
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Truth-table reference: count of ones per bit position decides each gate.
    function automatic logic [3:0] refGate(input string op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            int ones;
            ones = int'(a[i]) + int'(b[i]);
            case (op)
                "and":   r[i] = (ones == 2);
                "or":    r[i] = (ones >= 1);
                "xor":   r[i] = (ones == 1);
                default: r[i] = (int'(a[i]) == 0);
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", tag, got, expected, $time);
        end
    endtask

    task automatic checkComb();
        checkOutput("and_out4", and_out4, refGate("and", a4, b4));
        checkOutput("or_out4",  or_out4,  refGate("or",  a4, b4));
        checkOutput("not_out4", not_out4, refGate("not", a4, b4));
        checkOutput("and_out1", {3'b0, and_out1}, {3'b0, refGate("and", {3'b0, a1}, {3'b0, b1})});
        checkOutput("or_out1",  {3'b0, or_out1},  {3'b0, refGate("or",  {3'b0, a1}, {3'b0, b1})});
        checkOutput("not_out1", {3'b0, not_out1}, {3'b0, ~3'b0, 1'b0} & 4'b0001 | {3'b0, refGate("not", {3'b0, a1}, {3'b0, b1})} & 4'b0001);
`ifdef BASIC_GATES_XOR_EN
        checkOutput("xor_out4", xor_out4, refGate("xor", a4, b4));
        checkOutput("xor_out1", {3'b0, xor_out1}, refGate("xor", {3'b0, a1}, {3'b0, b1}));
`endif
    endtask

    task automatic checkRegs(input string phase);
        checkOutput({phase, "_and_q4"},   and_q4,   exp_and_q);
        checkOutput({phase, "_or_q4"},    or_q4,    exp_or_q);
        checkOutput({phase, "_not_q4"},   not_q4,   exp_not_q);
        checkOutput({phase, "_valid_q4"}, {3'b0, valid_q4}, {3'b0, exp_valid});
        checkOutput({phase, "_and_q1"},   {3'b0, and_q1}, {3'b0, exp_and_q[0]});
        checkOutput({phase, "_or_q1"},    {3'b0, or_q1},  {3'b0, exp_or_q[0]});
        checkOutput({phase, "_not_q1"},   {3'b0, not_q1}, {3'b0, exp_not_q[0]});
        checkOutput({phase, "_valid_q1"}, {3'b0, valid_q1}, {3'b0, exp_valid});
`ifdef BASIC_GATES_XOR_EN
        checkOutput({phase, "_xor_q4"}, xor_q4, exp_xor_q);
        checkOutput({phase, "_xor_q1"}, {3'b0, xor_q1}, {3'b0, exp_xor_q[0]});
`endif
    endtask

    // One clock cycle: drive on the falling edge, check combinational results
    // and that registers have not moved yet, then check them after the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rst = r;
        en  = e;
        a4  = a;
        b4  = b;
        a1  = a[0];
        b1  = b[0];
        #1;
        checkComb();
        checkRegs("pre");
        @(posedge clk);
        if (r) begin
            exp_and_q = '0;
            exp_or_q  = '0;
            exp_not_q = '0;
            exp_xor_q = '0;
            exp_valid = 1'b0;
        end else if (e) begin
            exp_and_q = refGate("and", a, b);
            exp_or_q  = refGate("or",  a, b);
            exp_not_q = refGate("not", a, b);
            exp_xor_q = refGate("xor", a, b);
            exp_valid = 1'b1;
        end
        #1;
        checkRegs("post");
    endtask

    initial begin
        // Reset first so the registered outputs become defined.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_and_q = '0;
        exp_or_q  = '0;
        exp_not_q = '0;
        exp_xor_q = '0;
        exp_valid = 1'b0;
        checkRegs("reset");

        // Exhaustive WIDTH=1 sweep, 250 ns per pair, while held in reset.
        for (int p = 0; p < 4; p++) begin
            logic [1:0] pair;
            logic [3:0] exp_and, exp_or, exp_not;
            pair = 2'(p);
            a1 = pair[1];
            b1 = pair[0];
            #250;
            exp_and = 4'b1000;
            exp_or  = 4'b1110;
            exp_not = 4'b0011;
            checkOutput("sweep_and1", {3'b0, and_out1}, {3'b0, exp_and[p]});
            checkOutput("sweep_or1",  {3'b0, or_out1},  {3'b0, exp_or[p]});
            checkOutput("sweep_not1", {3'b0, not_out1}, {3'b0, exp_not[p]});
        end

        // Latency: before the enabled edge regs stay at reset, after it they load.
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b1111);
        checkOutput("lat_and_q1",   {3'b0, and_q1},   4'b0001);
        checkOutput("lat_not_q1",   {3'b0, not_q1},   4'b0000);
        checkOutput("lat_valid_q1", {3'b0, valid_q1}, 4'b0001);

        // Enable hold: load 0/1, then three disabled edges with new operands.
        applyStimulus(1'b0, 1'b1, 4'b0000, 4'b1111);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
        checkOutput("hold_and_q1", {3'b0, and_q1}, 4'b0000);
        checkOutput("hold_or_q1",  {3'b0, or_q1},  4'b0001);
        checkOutput("hold_not_q1", {3'b0, not_q1}, 4'b0001);

        // Reset priority over enable, combinational path still live.
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111);
        checkOutput("rstpri_and_out4", and_out4, 4'b1111);
        checkOutput("rstpri_and_q4",   and_q4,   4'b0000);
        checkOutput("rstpri_valid_q4", {3'b0, valid_q4}, 4'b0000);

        // WIDTH=4 directed operands.
        applyStimulus(1'b0, 1'b1, 4'b1100, 4'b1010);
        checkOutput("w4_and_out", and_out4, 4'b1000);
        checkOutput("w4_or_out",  or_out4,  4'b1110);
        checkOutput("w4_not_out", not_out4, 4'b0011);
`ifdef BASIC_GATES_XOR_EN
        checkOutput("w4_xor_out", xor_out4, 4'b0110);
        checkOutput("w4_xor_q",   xor_q4,   4'b0110);
`endif

        // Random traffic with occasional reset and varying enable.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
